// File: rtl/four_bit_adder.sv
// Registered 4-bit ripple-carry adder with carry-out and signed overflow.
// One-cycle latency, one result per valid cycle, outputs held between results.
module four_bit_adder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] S,
    output logic       Cout,
    output logic       OVF,
    output logic       out_valid
);

    logic [4:0] carry;
    logic [3:0] sum_bits;
    logic       ovf_next;

    logic [3:0] s_reg;
    logic       cout_reg;
    logic       ovf_reg;
    logic       out_valid_reg;

    assign carry[0] = Cin;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_full_adder
            assign sum_bits[gi]  = A[gi] ^ B[gi] ^ carry[gi];
            assign carry[gi + 1] = (A[gi] & B[gi]) | (carry[gi] & (A[gi] ^ B[gi]));
        end
    endgenerate

    // Overflow: operands share a sign but the result sign differs from it.
    assign ovf_next = (A[3] == B[3]) && (sum_bits[3] != A[3]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_reg         <= 4'd0;
            cout_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= in_valid;
            if (in_valid) begin
                s_reg    <= sum_bits;
                cout_reg <= carry[4];
                ovf_reg  <= ovf_next;
            end
        end
    end

    assign S         = s_reg;
    assign Cout      = cout_reg;
    assign OVF       = ovf_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_four_bit_adder.sv
// Self-checking bench for four_bit_adder: directed cases, reset behaviour,
// and an exhaustive operand sweep with random idle cycles against an arithmetic model.
module tb_four_bit_adder;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] s;
    logic       cout;
    logic       ovf;
    logic       out_valid;

    int checks;
    int failures;

    logic [3:0] exp_s;
    logic       exp_cout;
    logic       exp_ovf;
    logic       exp_valid;

    four_bit_adder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (a),
        .B         (b),
        .Cin       (cin),
        .S         (s),
        .Cout      (cout),
        .OVF       (ovf),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, want);
        end
    endtask

    // Reference: plain integer arithmetic; overflow from the signed-range test.
    task automatic ref_add(input int av, input int bv, input int cv,
                           output logic [3:0] rs, output logic rc, output logic ro);
        int r;
        int sa;
        int sb;
        int sr;
        r  = av + bv + cv;
        rs = 4'(r % 16);
        rc = (r >= 16);
        sa = (av >= 8) ? av - 16 : av;
        sb = (bv >= 8) ? bv - 16 : bv;
        sr = sa + sb + cv;
        ro = (sr > 7) || (sr < -8);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_s"},     {4'd0, s},         {4'd0, exp_s});
        check({tag, "_cout"},  {7'd0, cout},      {7'd0, exp_cout});
        check({tag, "_ovf"},   {7'd0, ovf},       {7'd0, exp_ovf});
        check({tag, "_valid"}, {7'd0, out_valid}, {7'd0, exp_valid});
    endtask

    task automatic drive(input logic v, input logic [3:0] av, input logic [3:0] bv,
                         input logic cv, input string tag);
        @(negedge clk);
        in_valid = v;
        a        = av;
        b        = bv;
        cin      = cv;
        @(posedge clk);
        if (v) ref_add(int'(av), int'(bv), int'(cv), exp_s, exp_cout, exp_ovf);
        exp_valid = v;
        #1;
        $display("txn %s v=%0b A=%0d B=%0d Cin=%0b -> S=%0d Cout=%0b OVF=%0b out_valid=%0b",
                 tag, v, av, bv, cv, s, cout, ovf, out_valid);
        check_outputs(tag);
    endtask

    task automatic reset_expect();
        exp_s     = 4'd0;
        exp_cout  = 1'b0;
        exp_ovf   = 1'b0;
        exp_valid = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        a        = 4'd9;
        b        = 4'd9;
        cin      = 1'b1;
        reset_expect();

        // Held in reset with in_valid high: outputs stay at reset values.
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset");

        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;

        drive(1'b1, 4'd0, 4'd0, 1'b0, "zero");

        drive(1'b1, 4'd4, 4'd3, 1'b1, "seq0");
        check("seq0_const_s", {4'd0, s}, 8'd8);
        check("seq0_const_ovf", {7'd0, ovf}, 8'd1);
        drive(1'b1, 4'd3, 4'd7, 1'b1, "seq1");
        check("seq1_const_s", {4'd0, s}, 8'd11);
        drive(1'b1, 4'd8, 4'd4, 1'b0, "seq2");
        check("seq2_const_s", {4'd0, s}, 8'd12);
        drive(1'b1, 4'd5, 4'd9, 1'b1, "seq3");
        check("seq3_const_s", {4'd0, s}, 8'd15);

        drive(1'b1, 4'd15, 4'd15, 1'b1, "max");
        check("max_const_cout", {7'd0, cout}, 8'd1);
        check("max_const_ovf", {7'd0, ovf}, 8'd0);
        drive(1'b1, 4'd8, 4'd8, 1'b0, "negovf");
        check("negovf_const_s", {4'd0, s}, 8'd0);
        check("negovf_const_ovf", {7'd0, ovf}, 8'd1);

        // Hold: result 11, then idle cycles with random operands.
        drive(1'b1, 4'd4, 4'd6, 1'b1, "hold_load");
        for (int i = 0; i < 3; i++)
            drive(1'b0, 4'($urandom), 4'($urandom), 1'($urandom), "hold_idle");
        check("hold_const_s", {4'd0, s}, 8'd11);

        // Reset asserted mid-period while a valid set is presented.
        @(negedge clk);
        in_valid = 1'b1;
        a        = 4'd7;
        b        = 4'd7;
        cin      = 1'b1;
        #2;
        rst_n = 1'b0;
        reset_expect();
        #1;
        check_outputs("async_rst");
        @(posedge clk);
        #1;
        check_outputs("rst_held");
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_outputs("rst_release");
        drive(1'b1, 4'd2, 4'd3, 1'b0, "post_rst");

        // Exhaustive sweep with occasional idle cycles in between.
        for (int i = 0; i < 512; i++) begin
            if ($urandom_range(0, 7) == 0)
                drive(1'b0, 4'($urandom), 4'($urandom), 1'($urandom), "sweep_idle");
            drive(1'b1, 4'(i >> 5), 4'(i >> 1), 1'(i), "sweep");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
